// File: rtl/ula_arbitro_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state codes,
// ALU opcode map and the illegal-opcode test.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package ula_arbitro_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // ALU opcode map; 1110 and 1111 are unassigned
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;
    localparam logic [3:0] OP_NE   = 4'b1101;

    // Opcodes 1110 and 1111 have no ALU function behind them.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op[3:1] == 3'b111);
    endfunction

endpackage

// File: rtl/ula_arbitro_rr.sv
// Two-way round-robin grant: one-hot grant among valid requesters, ptr breaks ties.
// Latency: combinational. Backpressure: enable low forces grant to 00.
// Ports: valid0/valid1 requests, ptr tie-break owner, enable, grant one-hot out.
module rr_arbitro2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    input  logic       enable,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie ptr names the winner.
    always_comb begin
        grant    = 2'b00;
        grant[0] = enable & valid0 & (~valid1 | ~ptr);
        grant[1] = enable & valid1 & (~valid0 |  ptr);
    end

endmodule

// File: rtl/ula_arbitro.sv
// Round-robin arbiter/sequencer sharing one combinational 32-bit ALU between two requesters.
// Latency: accept at T, ALU evaluated in T+1, registered result valid from T+2.
// Backpressure: one op in flight; req ready is low whenever busy, result held until rsp_ready[id].
// Ports: req0_*/req1_* operation handshakes, rsp_* result handshake (one-hot valid),
//        alu_* operands to / results from the external ALU, busy = not IDLE.
module ula_arbitro
    import ula_arbitro_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_controle,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_controle,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_flag,
    output logic        rsp_err,
    output logic [3:0]  alu_controle,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out_32,
    input  logic        alu_out1,
    output logic        busy
);

    logic [1:0]  state;
    logic        ptr;
    logic        id;
    logic [1:0]  grant;
    logic [3:0]  op_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_err;

    rr_arbitro2 u_rr (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (ptr),
        .enable (state == IDLE),
        .grant  (grant)
    );

    // Grant only exists in IDLE, so ready doubles as the accept strobe.
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // The ALU always sees the last accepted op, so its inputs never toggle outside EXEC.
    assign alu_controle = op_ctl;
    assign alu_in1      = op_a;
    assign alu_in2      = op_b;

    assign op_err    = is_illegal(op_ctl) | ((op_ctl == OP_DIV) && (op_b == 32'd0));
    assign busy      = (state != IDLE);
    assign rsp_valid = {(state == RESP) & id, (state == RESP) & ~id};

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= PRIO_INIT;
            id       <= 1'b0;
            op_ctl   <= 4'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            rsp_data <= 32'd0;
            rsp_flag <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        id     <= grant[1];
                        op_ctl <= grant[1] ? req1_controle : req0_controle;
                        op_a   <= grant[1] ? req1_in1      : req0_in1;
                        op_b   <= grant[1] ? req1_in2      : req0_in2;
                        // Hand the tie-break to whoever did not just win.
                        ptr    <= ~grant[1];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Erroring ops return a clean zero result rather than ALU garbage.
                    rsp_err  <= op_err;
                    rsp_data <= op_err ? 32'd0 : alu_out_32;
                    rsp_flag <= op_err ? 1'b0  : alu_out1;
                    state    <= RESP;
                end
                RESP: begin
                    // Only the owner's ready completes the response.
                    if (rsp_ready[id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbitro.sv
module tb_ula_arbitro;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_controle, req1_controle;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_flag, rsp_err;
    logic [3:0]  alu_controle;
    logic [31:0] alu_in1, alu_in2;
    logic [31:0] alu_out_32;
    logic        alu_out1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ula_arbitro #(.PRIO_INIT(1'b0)) dut (
        .clock         (clock),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_controle (req0_controle),
        .req0_in1      (req0_in1),
        .req0_in2      (req0_in2),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_controle (req1_controle),
        .req1_in1      (req1_in1),
        .req1_in2      (req1_in2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_flag      (rsp_flag),
        .rsp_err       (rsp_err),
        .alu_controle  (alu_controle),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_out_32    (alu_out_32),
        .alu_out1      (alu_out1),
        .busy          (busy)
    );

    // Stand-in for the external ALU. Error cases return junk on purpose so the
    // arbiter's zero-forcing is visible.
    always_comb begin
        alu_out_32 = 32'd0;
        alu_out1   = 1'b0;
        case (alu_controle)
            4'b0000: alu_out_32 = alu_in1 + alu_in2;
            4'b0001: alu_out_32 = alu_in1 - alu_in2;
            4'b0011: begin
                if (alu_in2 == 32'd0) begin
                    alu_out_32 = 32'hFFFF_FFFF;
                    alu_out1   = 1'b1;
                end else begin
                    alu_out_32 = alu_in1 / alu_in2;
                end
            end
            4'b1010: begin
                alu_out1   = ($signed(alu_in1) < $signed(alu_in2));
                alu_out_32 = {31'd0, alu_out1};
            end
            4'b1111: begin
                alu_out_32 = 32'hDEAD_BEEF;
                alu_out1   = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int who);
        return (who == 0) ? req0_ready : req1_ready;
    endfunction

    // Issue one op on a requester, wait for accept and response, check, then complete.
    task automatic do_op(input string tag, input int who, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input logic exp_flag, input logic exp_err);
        int n;
        logic [1:0] onehot;
        onehot = (who == 0) ? 2'b01 : 2'b10;
        if (who == 0) begin
            req0_valid = 1'b1; req0_controle = op; req0_in1 = a; req0_in2 = b;
        end else begin
            req1_valid = 1'b1; req1_controle = op; req1_in1 = a; req1_in2 = b;
        end
        #1;
        n = 0;
        while (!rdy_of(who) && n < 10) begin
            @(negedge clock); n++;
        end
        chk({tag, "_accept"}, {31'd0, rdy_of(who)}, 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (rsp_valid == 2'b00 && n < 10) begin
            @(negedge clock); n++;
        end
        chk({tag, "_vld"},  {30'd0, rsp_valid}, {30'd0, onehot});
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_flag"}, {31'd0, rsp_flag}, {31'd0, exp_flag});
        chk({tag, "_err"},  {31'd0, rsp_err},  {31'd0, exp_err});
        rsp_ready = onehot;
        @(negedge clock);
        rsp_ready = 2'b00;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : stim
        int g_cnt, r_cnt;
        int grants[$];
        logic [31:0] r_data[$];
        logic        r_flag[$];
        logic [1:0]  r_vld[$];
        int seen;

        reset = 1'b1;
        req0_valid = 1'b0; req0_controle = 4'd0; req0_in1 = 32'd0; req0_in2 = 32'd0;
        req1_valid = 1'b0; req1_controle = 4'd0; req1_in1 = 32'd0; req1_in2 = 32'd0;
        rsp_ready  = 2'b00;
        @(negedge clock);
        @(negedge clock);

        // Reset state
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_vld",   {30'd0, rsp_valid}, 32'd0);
        chk("rst_data",  rsp_data, 32'd0);
        chk("rst_alu",   alu_in1 | alu_in2 | {28'd0, alu_controle}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single op, with EXEC-cycle visibility of the ALU operands
        req0_valid = 1'b1; req0_controle = 4'b0000; req0_in1 = 32'd5; req0_in2 = 32'd7;
        #1;
        chk("add_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        chk("add_exec_busy", {31'd0, busy}, 32'd1);
        chk("add_exec_vld",  {30'd0, rsp_valid}, 32'd0);
        chk("add_alu_in1",   alu_in1, 32'd5);
        chk("add_alu_in2",   alu_in2, 32'd7);
        @(negedge clock);
        chk("add_vld",  {30'd0, rsp_valid}, 32'd1);
        chk("add_data", rsp_data, 32'd12);
        chk("add_flag", {31'd0, rsp_flag}, 32'd0);
        chk("add_err",  {31'd0, rsp_err}, 32'd0);
        rsp_ready = 2'b01;
        @(negedge clock);
        rsp_ready = 2'b00;
        chk("add_done", {30'd0, rsp_valid}, 32'd0);

        // Contention from a fresh reset: ptr=0, grants must alternate 0,1,0
        do_reset();
        req0_valid = 1'b1; req0_controle = 4'b0001; req0_in1 = 32'd10; req0_in2 = 32'd3;
        req1_valid = 1'b1; req1_controle = 4'b1010; req1_in1 = 32'd2;  req1_in2 = 32'd9;
        rsp_ready  = 2'b11;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid != 2'b00) begin
                r_vld.push_back(rsp_valid);
                r_data.push_back(rsp_data);
                r_flag.push_back(rsp_flag);
            end
            @(negedge clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 2'b00;
        g_cnt = grants.size();
        r_cnt = r_vld.size();
        chk("cont_ngrant", g_cnt, 32'd3);
        chk("cont_nrsp",   r_cnt, 32'd3);
        if (g_cnt == 3) begin
            chk("cont_g0", grants[0], 32'd0);
            chk("cont_g1", grants[1], 32'd1);
            chk("cont_g2", grants[2], 32'd0);
        end
        if (r_cnt == 3) begin
            chk("cont_r0_vld",  {30'd0, r_vld[0]}, 32'd1);
            chk("cont_r0_data", r_data[0], 32'd7);
            chk("cont_r0_flag", {31'd0, r_flag[0]}, 32'd0);
            chk("cont_r1_vld",  {30'd0, r_vld[1]}, 32'd2);
            chk("cont_r1_data", r_data[1], 32'd1);
            chk("cont_r1_flag", {31'd0, r_flag[1]}, 32'd1);
            chk("cont_r2_vld",  {30'd0, r_vld[2]}, 32'd1);
        end
        @(negedge clock);
        chk("cont_idle", {31'd0, busy}, 32'd0);

        // Back-pressure: response held 5 cycles while both requesters knock
        req0_valid = 1'b1; req0_controle = 4'b0000; req0_in1 = 32'd1; req0_in2 = 32'd2;
        @(negedge clock);
        @(negedge clock);
        req1_valid = 1'b1; req1_controle = 4'b0000; req1_in1 = 32'd3; req1_in2 = 32'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_vld",   {30'd0, rsp_valid}, 32'd1);
            chk("bp_data",  rsp_data, 32'd3);
            chk("bp_flag",  {31'd0, rsp_flag}, 32'd0);
            chk("bp_busy",  {31'd0, busy}, 32'd1);
            chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 2'b01;
        @(negedge clock);
        rsp_ready = 2'b00;
        chk("bp_done", {30'd0, rsp_valid}, 32'd0);

        // Error cases and a legal divide
        do_op("divz",  1, 4'b0011, 32'd9,  32'd0, 32'd0,  1'b0, 1'b1);
        do_op("ill",   0, 4'b1111, 32'd1,  32'd2, 32'd0,  1'b0, 1'b1);
        do_op("div",   0, 4'b0011, 32'd9,  32'd3, 32'd3,  1'b0, 1'b0);
        do_op("slt",   1, 4'b1010, 32'd2,  32'd9, 32'd1,  1'b1, 1'b0);

        // Reset in EXEC drops the op; req0 wins afterwards (ptr back to 0)
        req0_valid = 1'b1; req0_controle = 4'b0000; req0_in1 = 32'd4; req0_in2 = 32'd4;
        #1;
        chk("rmo_accept", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rmo_busy", {31'd0, busy}, 32'd0);
        chk("rmo_vld",  {30'd0, rsp_valid}, 32'd0);
        chk("rmo_out",  rsp_data | {30'd0, rsp_flag, rsp_err}, 32'd0);
        chk("rmo_alu",  alu_in1 | alu_in2 | {28'd0, alu_controle}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (rsp_valid != 2'b00) seen++;
        end
        chk("rmo_no_rsp", seen, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rmo_ptr", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);

        // Wrong-side ready must not complete req0's response
        rsp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wrong_vld", {30'd0, rsp_valid}, 32'd1);
            @(negedge clock);
        end
        rsp_ready = 2'b01;
        @(negedge clock);
        rsp_ready = 2'b00;
        chk("wrong_done", {30'd0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
